// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register with EX/MEM + MEM/WB operand forwarding,
//             load-use bubble insertion and downstream hold/flush handling.
//  Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RA_W-1:0]  id_rs1_addr,
    input  logic [RA_W-1:0]  id_rs2_addr,
    input  logic [RA_W-1:0]  id_rd_addr,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_src_a_pc,
    input  logic             id_src_b_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             ex_hold,
    input  logic             ex_flush,
    input  logic             exmem_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_wdata,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA_W-1:0]  ex_rd_addr,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             load_use_hazard
);

    logic             valid_q,     valid_d;
    logic [WIDTH-1:0] pc_q,        pc_d;
    logic [WIDTH-1:0] rs1_data_q,  rs1_data_d;
    logic [WIDTH-1:0] rs2_data_q,  rs2_data_d;
    logic [WIDTH-1:0] imm_q,       imm_d;
    logic [RA_W-1:0]  rs1_addr_q,  rs1_addr_d;
    logic [RA_W-1:0]  rs2_addr_q,  rs2_addr_d;
    logic [RA_W-1:0]  rd_q,        rd_d;
    logic [3:0]       alu_ctrl_q,  alu_ctrl_d;
    logic             src_a_pc_q,  src_a_pc_d;
    logic             src_b_imm_q, src_b_imm_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q,  mem_read_d;
    logic             mem_write_q, mem_write_d;

    logic [WIDTH-1:0] w_fwd_rs1;
    logic [WIDTH-1:0] w_fwd_rs2;

    // EX/MEM is the younger producer, so it is applied last and wins.
    always_comb begin
        w_fwd_rs1 = rs1_data_q;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_addr_q))
            w_fwd_rs1 = memwb_wdata;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_addr_q))
            w_fwd_rs1 = exmem_result;

        w_fwd_rs2 = rs2_data_q;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_addr_q))
            w_fwd_rs2 = memwb_wdata;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_addr_q))
            w_fwd_rs2 = exmem_result;
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_write  = reg_write_q & valid_q;
    assign ex_mem_read   = mem_read_q  & valid_q;
    assign ex_mem_write  = mem_write_q & valid_q;
    assign alu_a         = src_a_pc_q  ? pc_q  : w_fwd_rs1;
    assign alu_b         = src_b_imm_q ? imm_q : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;

    // Both source fields are compared even for formats without an rs2.
    assign load_use_hazard = ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid &&
                             ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));

    assign id_ready = !ex_hold && !load_use_hazard;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_d        = rd_q;
        alu_ctrl_d  = alu_ctrl_q;
        src_a_pc_d  = src_a_pc_q;
        src_b_imm_d = src_b_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (ex_flush || (!ex_hold && load_use_hazard)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (ex_hold) begin
            // Capture forwarded values so a producer retiring mid-hold is not lost.
            rs1_data_d = w_fwd_rs1;
            rs2_data_d = w_fwd_rs2;
        end else begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            rd_d        = id_rd_addr;
            alu_ctrl_d  = id_alu_ctrl;
            src_a_pc_d  = id_src_a_pc;
            src_b_imm_d = id_src_b_imm;
            reg_write_d = id_valid & id_reg_write;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
            alu_ctrl_q  <= 4'b0000;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_q        <= rd_d;
            alu_ctrl_q  <= alu_ctrl_d;
            src_a_pc_q  <= src_a_pc_d;
            src_b_imm_q <= src_b_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Directed scenarios plus randomized traffic against an
//             instruction-level reference model of the ID/EX stage.
//  Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        ex_hold, ex_flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_wdata;
    logic        ex_valid;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

    int n_total = 0;
    int n_pass  = 0;

    id_ex_stage #(.WIDTH(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_ctrl(id_alu_ctrl), .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .ex_hold(ex_hold), .ex_flush(ex_flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  a1, a2, rd;
        logic [3:0]  ctl;
        logic        sa, sb, rw, mr, mw;
    } ex_t;
    ex_t m;

    // Value of register 'addr' as seen now: newest in-flight producer, else the file value.
    function automatic logic [31:0] newest(input logic [4:0] addr, input logic [31:0] regval);
        if (addr == 5'd0) return regval;
        if (exmem_reg_write && exmem_rd == addr) return exmem_result;
        if (memwb_reg_write && memwb_rd == addr) return memwb_wdata;
        return regval;
    endfunction

    function automatic logic model_hazard();
        return m.v && m.mr && m.rd != 5'd0 && id_valid &&
               (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
    endfunction

    task automatic tick();
        ex_t n;
        n = m;
        if (!rst_n) begin
            n = '0;
        end else if (ex_flush || (!ex_hold && model_hazard())) begin
            n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
        end else if (ex_hold) begin
            n.r1 = newest(m.a1, m.r1);
            n.r2 = newest(m.a2, m.r2);
        end else begin
            n = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr,
                  id_rd_addr, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
                  id_valid & id_reg_write, id_valid & id_mem_read, id_valid & id_mem_write};
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = 0;
        id_src_a_pc = 0; id_src_b_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        ex_hold = 0; ex_flush = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [4:0] a1, input logic [31:0] d1,
                           input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [4:0] rd, input logic [3:0] ctl, input logic sa,
                           input logic sb, input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_pc = pc; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2;
        id_rs2_data = d2; id_imm = imm; id_rd_addr = rd; id_alu_ctrl = ctl;
        id_src_a_pc = sa; id_src_b_imm = sb; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        m = '0;
        #12;
        n_total++;
        if ({ex_valid, ex_pc, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd_addr,
             ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard} !== '0)
            $display("FAIL reset_state: valid=%0b pc=%h a=%h b=%h ctl=%h sd=%h rd=%0d want all 0",
                     ex_valid, ex_pc, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd_addr);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        present(32'h40, 5'd1, 32'h11, 5'd2, 32'h22, 32'h33, 5'd9, 4'hA, 1, 1, 1, 1, 1);
        tick();
        clear_inputs();
        #2 rst_n = 0;
        #1;
        m = '0;
        n_total++;
        if ({ex_valid, ex_pc, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd_addr,
             ex_reg_write, ex_mem_read, ex_mem_write} !== '0)
            $display("FAIL reset_midstream: valid=%0b pc=%h a=%h b=%h ctl=%h rd=%0d want all 0",
                     ex_valid, ex_pc, alu_a, alu_b, alu_ctrl, ex_rd_addr);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_passthrough();
        present(32'h100, 5'd1, 32'd5, 5'd2, 32'd99, 32'd7, 5'd3, 4'h0, 0, 1, 1, 0, 0);
        tick();
        clear_inputs();
        #1;
        n_total++;
        if ({alu_a, alu_b, ex_valid, ex_rd_addr, ex_reg_write, ex_pc} !==
            {32'd5, 32'd7, 1'b1, 5'd3, 1'b1, 32'h100})
            $display("FAIL addi_pass: a=%0d b=%0d v=%0b rd=%0d rw=%0b pc=%h want 5 7 1 3 1 100",
                     alu_a, alu_b, ex_valid, ex_rd_addr, ex_reg_write, ex_pc);
        else n_pass++;
    endtask

    task automatic test_forward_priority();
        present(32'h104, 5'd4, 32'h1111, 5'd0, 32'h0, 32'h0, 5'd10, 4'h1, 0, 0, 1, 0, 0);
        tick();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd4; exmem_result = 32'hAAAA;
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_wdata = 32'hBBBB;
        #1; n_total++;
        if (alu_a !== 32'hAAAA) $display("FAIL fwd_exmem: alu_a=%h want AAAA", alu_a);
        else n_pass++;
        exmem_reg_write = 0;
        #1; n_total++;
        if (alu_a !== 32'hBBBB) $display("FAIL fwd_memwb: alu_a=%h want BBBB", alu_a);
        else n_pass++;
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1; n_total++;
        if (alu_a !== 32'h1111) $display("FAIL fwd_x0: alu_a=%h want 1111", alu_a);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_load_use();
        present(32'h200, 5'd1, 32'h8, 5'd0, 32'h0, 32'h4, 5'd5, 4'h0, 0, 1, 1, 1, 0);
        tick();
        present(32'h204, 5'd2, 32'h3, 5'd5, 32'h77, 32'h0, 5'd8, 4'h0, 0, 0, 1, 0, 0);
        #1; n_total++;
        if ({load_use_hazard, id_ready} !== 2'b10)
            $display("FAIL lu_detect: hazard=%0b ready=%0b want 1 0", load_use_hazard, id_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0)
            $display("FAIL lu_bubble: v=%0b rw=%0b mr=%0b mw=%0b want 0", ex_valid,
                     ex_reg_write, ex_mem_read, ex_mem_write);
        else n_pass++;
        n_total++;
        if ({load_use_hazard, id_ready} !== 2'b01)
            $display("FAIL lu_release: hazard=%0b ready=%0b want 0 1", load_use_hazard, id_ready);
        else n_pass++;
        tick();
        clear_inputs();
        n_total++;
        if ({ex_valid, ex_rd_addr, ex_pc} !== {1'b1, 5'd8, 32'h204})
            $display("FAIL lu_accept: v=%0b rd=%0d pc=%h want 1 8 204", ex_valid, ex_rd_addr, ex_pc);
        else n_pass++;
    endtask

    task automatic test_hold_retire();
        present(32'h300, 5'd6, 32'h0F0F, 5'd0, 32'h0, 32'h0, 5'd11, 4'h2, 0, 0, 1, 0, 0);
        tick();
        present(32'h304, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd12, 4'h0, 0, 0, 1, 0, 0);
        ex_hold = 1;
        memwb_reg_write = 1; memwb_rd = 5'd6; memwb_wdata = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            #1; n_total++;
            if ({alu_a, id_ready, ex_valid} !== {32'h1234, 1'b0, 1'b1})
                $display("FAIL hold_cycle%0d: alu_a=%h ready=%0b v=%0b want 1234 0 1",
                         c, alu_a, id_ready, ex_valid);
            else n_pass++;
            tick();
            memwb_reg_write = 0;
        end
        clear_inputs();
        #1; n_total++;
        if ({alu_a, ex_pc} !== {32'h1234, 32'h300})
            $display("FAIL hold_after: alu_a=%h pc=%h want 1234 300", alu_a, ex_pc);
        else n_pass++;
    endtask

    task automatic test_flush_beats_hold();
        present(32'h400, 5'd1, 32'h0, 5'd2, 32'h0, 32'h8, 5'd0, 4'h0, 0, 1, 0, 0, 1);
        tick();
        clear_inputs();
        ex_flush = 1; ex_hold = 1;
        tick();
        clear_inputs();
        n_total++;
        if ({ex_valid, ex_mem_write} !== 2'b00)
            $display("FAIL flush_hold: v=%0b mw=%0b want 0 0", ex_valid, ex_mem_write);
        else n_pass++;
    endtask

    task automatic test_store_forward();
        present(32'h500, 5'd2, 32'h100, 5'd7, 32'h5555, 32'h10, 5'd0, 4'h0, 0, 1, 0, 0, 1);
        tick();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'hDEAD;
        #1; n_total++;
        if ({ex_store_data, alu_b, ex_mem_write} !== {32'hDEAD, 32'h10, 1'b1})
            $display("FAIL store_fwd: sd=%h alu_b=%h mw=%0b want DEAD 10 1",
                     ex_store_data, alu_b, ex_mem_write);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_random();
        logic [31:0] exp_a, exp_b, exp_sd;
        logic        exp_hz;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7)
                present($urandom, 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)),
                        $urandom, $urandom, 5'($urandom_range(0, 3)), 4'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                        1'($urandom));
            else
                id_valid = 0;
            ex_hold = ($urandom_range(0, 5) == 0);
            ex_flush = ($urandom_range(0, 9) == 0);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_wdata = $urandom;
            #1;
            exp_hz = model_hazard();
            exp_sd = newest(m.a2, m.r2);
            exp_a  = m.sa ? m.pc : newest(m.a1, m.r1);
            exp_b  = m.sb ? m.imm : exp_sd;
            n_total++;
            if ({load_use_hazard, id_ready} !== {exp_hz, !ex_hold && !exp_hz})
                $display("FAIL rnd_hazard[%0d]: hz=%0b rdy=%0b want %0b %0b", i,
                         load_use_hazard, id_ready, exp_hz, !ex_hold && !exp_hz);
            else n_pass++;
            n_total++;
            if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== {m.v, m.rw, m.mr, m.mw})
                $display("FAIL rnd_ctrl[%0d]: got %b want %b", i,
                         {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
                         {m.v, m.rw, m.mr, m.mw});
            else n_pass++;
            if (m.v) begin
                n_total++;
                if ({ex_pc, alu_a, alu_b, ex_store_data, ex_rd_addr, alu_ctrl} !==
                    {m.pc, exp_a, exp_b, exp_sd, m.rd, m.ctl})
                    $display("FAIL rnd_data[%0d]: pc=%h a=%h b=%h sd=%h rd=%0d ctl=%h want %h %h %h %h %0d %h",
                             i, ex_pc, alu_a, alu_b, ex_store_data, ex_rd_addr, alu_ctrl,
                             m.pc, exp_a, exp_b, exp_sd, m.rd, m.ctl);
                else n_pass++;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_forward_priority();
        test_load_use();
        test_hold_retire();
        test_flush_beats_hold();
        test_store_forward();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage RV32I core; sits directly upstream of the ALU and feeds its operands and alu_ctrl.
- Registers decoded instruction fields and resolves operand forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles, and honours downstream hold and flush.

Parameters:
- WIDTH, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_pc  in  WIDTH  instruction PC.
- id_rs1_data, id_rs2_data  in  WIDTH  register-file read data.
- id_imm  in  WIDTH  sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  register indices.
- id_alu_ctrl  in  4  ALU opcode, passed through.
- id_src_a_pc  in  1  operand A = PC (AUIPC/JAL).
- id_src_b_imm  in  1  operand B = immediate.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- ex_hold  in  1  downstream stall; freeze EX contents.
- ex_flush  in  1  branch or jump redirect; kill EX contents.
- exmem_reg_write  in  1  EX/MEM writes rd (valid-qualified).
- exmem_rd  in  RA_W  EX/MEM destination.
- exmem_result  in  WIDTH  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes rd (valid-qualified).
- memwb_rd  in  RA_W  MEM/WB destination.
- memwb_wdata  in  WIDTH  MEM/WB writeback data.
- ex_valid  out  1  EX holds a live instruction.
- ex_pc  out  WIDTH  registered PC.
- alu_a, alu_b  out  WIDTH  ALU operands, after forwarding.
- alu_ctrl  out  4  registered ALU opcode.
- ex_store_data  out  WIDTH  forwarded rs2 for stores.
- ex_rd_addr  out  RA_W  registered rd.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by ex_valid.
- load_use_hazard  out  1  to hazard unit; freezes PC and IF/ID.

Behaviour:
- Reset (async, rst_n=0):
  - All registers clear: ex_valid=0, ex_pc=0, alu_ctrl=4'b0000, rd=0, imm=0, operands=0, all control bits 0.
  - The outputs follow directly: alu_a=0, alu_b=0, ex_store_data=0.
  - Reset mid-operation discards the in-flight instruction.
- Load-use hazard (combinational):
  - load_use_hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Compare on both addresses regardless of instruction format.
- Ready: id_ready = !ex_hold & !load_use_hazard.
- Register update priority each rising edge, first match wins:
  1. ex_flush=1: bubble (ex_valid=0, ex_reg_write, ex_mem_read, ex_mem_write=0). Flush beats hold.
  2. ex_hold=1: keep all fields. Latch the currently forwarded rs1/rs2 values into the operand registers, so forwarding sources that retire during the hold are not lost.
  3. load_use_hazard=1: bubble.
  4. Otherwise: capture all id_* fields; ex_valid=id_valid. When id_valid=0, clear the control bits.
- Forwarding (combinational from registered rs addresses and operands):
  - fwd_rs1 = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs1.
  - Else memwb_wdata if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs1.
  - Else the registered rs1 data. fwd_rs2 resolves the same way.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand select:
  - alu_a = src_a_pc ? ex_pc : fwd_rs1.
  - alu_b = src_b_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2, always.
- Latency: an accepted instruction appears on the EX outputs one cycle after acceptance. Forwarding adds no cycle.
- Bubble contents: data fields retain their prior values (don't-care). Control outputs are guaranteed 0.
- Widths: all operand paths are WIDTH bits, with no extension. alu_ctrl passes through unchanged.

Test Plan:
- Reset then a pass-through instruction:
  - Assert rst_n=0 mid-stream: all outputs 0 immediately.
  - Release, then present ADDI: rs1_data=5, imm=7, src_b_imm=1, rd=3.
  - Next cycle: alu_a=5, alu_b=7, ex_valid=1, ex_rd_addr=3, ex_reg_write=1.
- Forward priority:
  - Setup: EX rs1=x4; exmem_rd=4, exmem_result=0xAAAA; memwb_rd=4, memwb_wdata=0xBBBB; both write enables 1. Check alu_a=0xAAAA.
  - Drop exmem_reg_write: alu_a=0xBBBB.
  - Set both rd=0: alu_a = registered rs1 data.
- Load-use:
  - Setup: EX holds LW x5; ID holds ADD with rs2=x5.
  - Same cycle: load_use_hazard=1, id_ready=0.
  - Next edge: EX bubble (ex_valid=0, controls 0).
  - Following cycle: hazard=0 and the ADD is accepted.
- Hold with a retiring source:
  - Setup: EX rs1=x6; memwb_rd=6, memwb_wdata=0x1234.
  - Assert ex_hold for 3 cycles, dropping memwb_reg_write after cycle 1.
  - alu_a stays 0x1234 throughout; id_ready=0 throughout.
- Flush beats hold: ex_flush=1 and ex_hold=1 together -> next cycle ex_valid=0, ex_mem_write=0.
- Store forwarding:
  - Setup: SW with rs2=x7 and src_b_imm=1; exmem_rd=7, exmem_result=0xDEAD.
  - Check ex_store_data=0xDEAD and alu_b=imm.
